fifo_rr_arbiter: RTL and testbench

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

---
 rtl/fifo_rr_arbiter_pkg.sv | 13 +
 rtl/fifo_flops.sv | 62 ++++++
 rtl/fifo_rr_arbiter.sv | 82 ++++++++
 tb/tb_fifo_rr_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared defaults and helpers for the round-robin producer arbiter and its FIFO.
package fifo_rr_arbiter_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned BITS_DEF  = 16;
  localparam int unsigned DEPTH_DEF = 16;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_flops.sv
// Flop-based synchronous FIFO: head presented combinationally on Dout.
module fifo_flops
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned BITS  = BITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [BITS-1:0] Din,
  output logic [BITS-1:0] Dout,
  output logic            pndng,
  output logic            full
);

  localparam int unsigned AW = idx_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign pndng   = (cnt_q != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && pndng;
  assign Dout    = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_q] <= Din;
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter granting one producer per cycle into a shared FIFO.
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned BITS  = BITS_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*BITS-1:0]    din_bus,
  output logic [N_REQ-1:0]         gnt,
  input  logic                     pop,
  output logic [BITS-1:0]          Dout,
  output logic                     pndng,
  output logic                     full,
  output logic [idx_w(N_REQ)-1:0]  last_id
);

  localparam int unsigned IW = idx_w(N_REQ);

  logic [IW-1:0]   ptr_q, ptr_d, last_q, last_d, gidx, cand;
  logic            any_gnt, fifo_full;
  logic [BITS-1:0] fifo_din;

  // Scan upward from ptr with wrap; the first requester wins.
  always_comb begin
    gnt     = '0;
    gidx    = '0;
    cand    = '0;
    any_gnt = 1'b0;
    if (!rst && !fifo_full) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        cand = IW'((32'(ptr_q) + k) % N_REQ);
        if (!any_gnt && req[cand]) begin
          gidx      = cand;
          gnt[cand] = 1'b1;
          any_gnt   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    last_d = last_q;
    if (any_gnt) begin
      last_d = gidx;
      ptr_d  = (32'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
    end
  end

  assign fifo_din = din_bus[32'(gidx)*BITS +: BITS];
  assign full     = fifo_full;
  assign last_id  = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      last_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
    end
  end

  fifo_flops #(
    .DEPTH (DEPTH),
    .BITS  (BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (any_gnt),
    .pop   (pop),
    .Din   (fifo_din),
    .Dout  (Dout),
    .pndng (pndng),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed and randomized checks of fifo_rr_arbiter against a queue-based model.
module tb_fifo_rr_arbiter;

  localparam int N = 4;
  localparam int B = 16;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*B-1:0] din_bus;
  logic [N-1:0]   gnt;
  logic           pop;
  logic [B-1:0]   Dout;
  logic           pndng;
  logic           full;
  logic [1:0]     last_id;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(
    .N_REQ (N),
    .BITS  (B),
    .DEPTH (D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .din_bus (din_bus),
    .gnt     (gnt),
    .pop     (pop),
    .Dout    (Dout),
    .pndng   (pndng),
    .full    (full),
    .last_id (last_id)
  );

  int errors = 0;
  int checks = 0;

  logic [B-1:0] q[$];
  int           m_ptr;
  int           m_last;
  int           seqno[N];
  logic [N-1:0] obs_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_din();
    for (int i = 0; i < N; i++) din_bus[i*B +: B] = B'(i*256 + seqno[i]);
  endtask

  function automatic int model_gnt(input logic r, input logic [N-1:0] rq);
    if (r || q.size() == D) return -1;
    for (int k = 0; k < N; k++)
      if (rq[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic step(input logic r, input logic [N-1:0] rq, input logic p);
    int           g;
    logic [N-1:0] eg;
    rst = r;
    req = rq;
    pop = p;
    #1;
    g  = model_gnt(r, rq);
    eg = (g < 0) ? '0 : N'(1) << g;
    obs_gnt = gnt;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (!r) begin
      chk("pndng", 32'(pndng), 32'(q.size() > 0));
      chk("full", 32'(full), 32'(q.size() == D));
      chk("last_id", 32'(last_id), 32'(m_last));
      if (q.size() > 0) chk("Dout", 32'(Dout), 32'(q[0]));
    end
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_ptr  = 0;
      m_last = 0;
    end else begin
      if (p && q.size() > 0) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back(din_bus[g*B +: B]);
        m_ptr  = (g + 1) % N;
        m_last = g;
        seqno[g]++;
      end
    end
    update_din();
    @(negedge clk);
  endtask

  initial begin
    logic         r, p;
    logic [N-1:0] rq;
    rst = 1'b1;
    req = '0;
    pop = 1'b0;
    m_ptr = 0;
    m_last = 0;
    for (int i = 0; i < N; i++) seqno[i] = 0;
    update_din();
    @(negedge clk);

    repeat (5) step(1'b1, '0, 1'b0);
    chk("rst_pndng", 32'(pndng), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_last_id", 32'(last_id), 32'd0);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'b1111, 1'b0);
      chk("rr_seq", 32'(obs_gnt), 32'(1 << (i % 4)));
    end
    chk("full_after16", 32'(full), 32'd1);

    step(1'b0, 4'b0010, 1'b1);
    chk("full_pop_no_gnt", 32'(obs_gnt), 32'd0);
    step(1'b0, 4'b0010, 1'b0);
    chk("refill_gnt", 32'(obs_gnt), 32'b0010);
    chk("refull", 32'(full), 32'd1);

    repeat (20) step(1'b0, '0, 1'b1);

    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b1001, 1'b0);
    chk("ptr3_gnt", 32'(obs_gnt), 32'b1000);
    step(1'b0, 4'b1001, 1'b0);
    chk("wrap_gnt", 32'(obs_gnt), 32'b0001);

    repeat (5) step(1'b0, '0, 1'b1);
    repeat (20) step(1'b0, '0, 1'b1);
    chk("empty_pop_pndng", 32'(pndng), 32'd0);
    chk("empty_pop_full", 32'(full), 32'd0);
    chk("empty_pop_gnt", 32'(obs_gnt), 32'd0);

    repeat (8) step(1'b0, 4'b0001, 1'b0);
    chk("eight_stored", 32'(pndng), 32'd1);
    step(1'b1, 4'b1111, 1'b0);
    chk("midrst_gnt", 32'(obs_gnt), 32'd0);
    chk("midrst_pndng", 32'(pndng), 32'd0);
    chk("midrst_last_id", 32'(last_id), 32'd0);
    step(1'b0, 4'b1111, 1'b0);
    chk("post_rst_gnt", 32'(obs_gnt), 32'b0001);

    repeat (4) step(1'b0, 4'b0001, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b0100, 1'b1);
      chk("steady_last_id", 32'(last_id), 32'd2);
      chk("steady_pndng", 32'(pndng), 32'd1);
      chk("steady_notfull", 32'(full), 32'd0);
    end

    // Randomized phases with varying pop pressure to visit empty and full.
    for (int ph = 0; ph < 4; ph++) begin
      repeat (150) begin
        r  = ($urandom_range(0, 79) == 0);
        rq = N'($urandom);
        case (ph)
          0:       p = ($urandom_range(0, 3) == 0);
          1:       p = ($urandom_range(0, 3) != 0);
          2:       p = $urandom_range(0, 1) == 1;
          default: p = ($urandom_range(0, 9) == 0);
        endcase
        step(r, rq, p);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
